sram_pixel_writer: RTL

Downstream stage of the UART pixel receiver: turns its byte stream (`pixel_value` plus post-incremented `addr_store`) into byte-lane writes on the DE2-115 16-bit asynchronous SRAM. After the image is fully stored, it provides a single-outstanding read port that the display/HDR datapath uses to fetch pixels by index. It owns the SRAM pins exclusively.

---
 rtl/hdr_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/sram_pixel_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hdr_pkg.sv
// Shared types for the pixel SRAM path: image geometry, writer FSM states, FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hdr_pkg;

    // Pixel bytes in one 640x480 8-bit image.
    localparam int unsigned IMAGE_SIZE = 307200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_RD_ADDR,
        S_RD_DATA
    } sram_state_e;

    // One captured byte and the pixel index it belongs to.
    typedef struct packed {
        logic [18:0] idx;
        logic [7:0]  data;
    } pix_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; DEPTH must be a power of two, at least 2.
// Latency: a written entry is visible at rd_dat the cycle after the write.
// Backpressure: writes are dropped while full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             avm_clk,
    input  logic             avm_rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign rd_dat = mem_q[rptr_q];
    assign do_rd  = rd_rdy & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_wr  = wr_vld & (~full | do_rd);

    // Next storage, pointer and occupancy values.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_wr) begin
            mem_d[wptr_q] = wr_dat;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards any queued entries.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_pixel_writer.sv
// Captures receiver bytes into a FIFO, writes them as byte lanes to the async SRAM, then serves pixel reads.
// Latency: addr_store change at N -> WE_N low at N+3; accepted read at N -> rd_valid at N+3.
// Backpressure: bytes arriving with the FIFO full are dropped (sticky overflow); reads only when rd_ready.
module sram_pixel_writer #(
    parameter int unsigned IMAGE_SIZE = 307200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [7:0]  pixel_value,
    input  logic [19:0] addr_store,
    input  logic        store_finish,
    input  logic        rd_req,
    input  logic [18:0] rd_idx,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        load_done,
    output logic        overflow,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    import hdr_pkg::*;

    sram_state_e state_q, state_d;
    logic [19:0] prev_addr_q, prev_addr_d;
    pix_entry_t  wr_ent_q, wr_ent_d;
    logic [18:0] rd_idx_q, rd_idx_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        fin_seen_q, fin_seen_d;
    logic        load_done_q, load_done_d;
    logic        overflow_q, overflow_d;

    pix_entry_t  push_ent, pop_ent;
    logic        push_vld, fifo_pop, fifo_full, fifo_empty, dq_oe;

    // A new byte is any change of the receiver counter; counter value 0 carries no byte.
    assign push_vld      = (addr_store != prev_addr_q) && (addr_store != 20'd0);
    assign push_ent.idx  = addr_store[18:0] - 19'd1;
    assign push_ent.data = pixel_value;
    assign fifo_pop      = (state_q == S_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH ($bits(pix_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .wr_vld  (push_vld),
        .wr_dat  (push_ent),
        .rd_rdy  (fifo_pop),
        .rd_dat  (pop_ent),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_ready  = load_done_q && (state_q == S_IDLE) && fifo_empty;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign load_done = load_done_q;
    assign overflow  = overflow_q;

    // Next state: pending writes always take priority over reads.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_WR_SETUP;
                end else if (rd_ready && rd_req) begin
                    state_d = S_RD_ADDR;
                end
            end
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: state_d = S_IDLE;
            S_RD_ADDR:  state_d = S_RD_DATA;
            S_RD_DATA:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of capture, read-path and status registers.
    always_comb begin
        prev_addr_d = addr_store;
        wr_ent_d    = fifo_pop ? pop_ent : wr_ent_q;
        rd_idx_d    = (rd_ready && rd_req) ? rd_idx : rd_idx_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        if (state_q == S_RD_DATA) begin
            rd_data_d  = rd_idx_q[0] ? SRAM_DQ[15:8] : SRAM_DQ[7:0];
            rd_valid_d = 1'b1;
        end
        fin_seen_d  = fin_seen_q | store_finish;
        load_done_d = load_done_q | (fin_seen_q && fifo_empty && (state_q == S_IDLE));
        overflow_d  = overflow_q | (push_vld && fifo_full && !fifo_pop);
    end

    // SRAM strobes decoded from the current state so reset releases them immediately.
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        case (state_q)
            S_WR_SETUP, S_WR_PULSE: begin
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = (state_q != S_WR_PULSE);
                SRAM_ADDR = {2'b00, wr_ent_q.idx[18:1]};
                SRAM_LB_N = wr_ent_q.idx[0];
                SRAM_UB_N = ~wr_ent_q.idx[0];
                dq_oe     = 1'b1;
            end
            S_RD_ADDR, S_RD_DATA: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_ADDR = {2'b00, rd_idx_q[18:1]};
            end
            default: ;
        endcase
    end

    // The byte goes out on both halves; the lane strobes pick which one the SRAM takes.
    assign SRAM_DQ = dq_oe ? {wr_ent_q.data, wr_ent_q.data} : 16'hzzzz;

    // State registers.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_q     <= S_IDLE;
            prev_addr_q <= '0;
            wr_ent_q    <= '0;
            rd_idx_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            fin_seen_q  <= 1'b0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_addr_q <= prev_addr_d;
            wr_ent_q    <= wr_ent_d;
            rd_idx_q    <= rd_idx_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            fin_seen_q  <= fin_seen_d;
            load_done_q <= load_done_d;
            overflow_q  <= overflow_d;
        end
    end

    // The receiver never produces an index past the end of the image.
    assert property (@(posedge avm_clk) disable iff (!avm_rst)
        !(push_vld && (32'(push_ent.idx) >= IMAGE_SIZE)));

endmodule
